token_pop_scheduler: RTL and testbench
======================================

# token_pop_scheduler

Token-engine sequencer directly upstream of the PE array controller. Steps each tile through IDLE, PREHEAT, NORMAL_LOOP, DRAIN and DONE. Drives the preheat/normal-loop state flags plus the per-column ifmap pop, ipsum pop and opsum push matrices that the PE array controller turns into PE stall/enable matrices. Never pops an empty FIFO and never pushes into a FIFO lacking room.

## Interface
Parameters:
- NUM_COL, 32, PE array columns (matrix width)
- PIPE_LAT, 4, cycles from a normal-loop pop to the matching opsum push
- LEN_W, 16, width of the tile token count

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start_i  in  1  launch one tile; honoured only in IDLE
- layer_type_i  in  2  layer type; sampled at start
- accumulate_i  in  1  tile consumes ipsum; sampled at start
- num_cols_i  in  6  active columns; sampled at start; 0 or >32 treated as 32
- tile_len_i  in  LEN_W  normal-loop tokens per column; sampled at start
- ifmap_fifo_empty_matrix_i  in  NUM_COL  per-column ifmap FIFO empty
- ipsum_fifo_empty_matrix_i  in  NUM_COL  per-column ipsum FIFO empty
- opsum_fifo_afull_matrix_i  in  NUM_COL  per-column; low guarantees ≥PIPE_LAT free entries
- preheat_state_o  out  1  state == PREHEAT
- normal_loop_state_o  out  1  state == NORMAL_LOOP
- ifmap_fifo_pop_matrix_o  out  NUM_COL  ifmap pop per column
- ipsum_fifo_pop_matrix_o  out  NUM_COL  ipsum pop per column
- ipsum_fifo_push_matrix_o  out  NUM_COL  opsum push per column
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse in DONE

## Operation
- Start capture: start_i in IDLE registers cfg (layer_type, accumulate, col_mask = (1<<n)-1, tile_len), zeroes counters and enters PREHEAT. start_i in any other state is ignored.
- PREHEAT (systolic skew fill): column counter k runs 0..n-1.
  - Each cycle pops column k only, gated by !ifmap_empty[k].
  - k advances only on an actual pop.
  - After the pop of column n-1, next state is NORMAL_LOOP.
- NORMAL_LOOP: issue condition fire is true when, over every active column:
  - ifmap FIFO is non-empty;
  - ipsum FIFO is non-empty, or accumulate is 0;
  - opsum afull is low.
- When fire is true:
  - ifmap_pop = col_mask;
  - ipsum_pop = col_mask if accumulate, else 0;
  - token counter increments.
  - Pops are all-or-nothing across columns.
  - When the counter reaches tile_len, next state is DRAIN.
  - tile_len = 0 skips NORMAL_LOOP: PREHEAT exits straight to DRAIN.
- Push pipeline: a PIPE_LAT-deep shift register of fire bits. ipsum_fifo_push_matrix_o = col_mask when the tail bit is set, else 0. The register shifts every cycle in every state.
- DRAIN: no pops. Stays until the push pipeline is all-zero, then enters DONE.
- DONE: done_o = 1 for one cycle, then IDLE.
- layer_type is stored for the downstream controller and does not alter sequencing.

## Timing
- Reset: state IDLE; counters, cfg registers and push pipeline cleared. Every output resets to 0.
- Reset mid-tile: same as above; in-flight pushes are discarded.
- State flags, busy_o and done_o decode the registered state (no input-to-output path).
- Pop matrices are combinational from the registered state and the current-cycle empty/afull inputs. The FIFO samples the pop on the same edge.
- start_i at edge t gives busy_o and preheat_state_o high from t+1. The first possible ifmap pop is also at t+1.
- A fire at cycle c produces the push at cycle c+PIPE_LAT.
- Minimum tile duration from start: 1 + n + tile_len + PIPE_LAT + 1 cycles.
- A stalled cycle (fire = 0) holds every counter.
- The push pipeline keeps shifting during stalls. The afull contract provides the space for these pushes.

## Configuration
- TOKEN_SCHED_PERF_EN defined:
  - adds output stall_cycles_o [31:0], the count of NORMAL_LOOP cycles with fire = 0;
  - the count saturates at 0xFFFFFFFF;
  - it is cleared at start and on reset.
- TOKEN_SCHED_PERF_EN undefined: no port and no counter logic.

## Structure
- token_engine_pkg holds:
  - the tsched_state_e enum (IDLE, PREHEAT, NORMAL_LOOP, DRAIN, DONE);
  - the layer_type_e enum (PW=0, DW=1, STD=2, LIN=3);
  - NUM_COL and PIPE_LAT defaults.
- Sub-module token_push_delay: parameterised PIPE_LAT shift register with an all-zero flag, used for the push pipeline and DRAIN exit.

## Test plan
- Nominal tile: n = 4, tile_len = 3, accumulate = 1, FIFOs never empty.
  - Preheat pops 0x1, 0x2, 0x4, 0x8 on consecutive cycles.
  - Then three cycles of ifmap_pop = ipsum_pop = 0xF.
  - Pushes of 0xF appear 4 cycles after each pop.
  - done_o at cycle 13 after start.
- Preheat stall: ifmap_empty[2] high for 5 cycles. Column-2 pop is held, then issued once; no pop while empty.
- Normal-loop backpressure:
  - opsum_afull[31] high with n = 32: zero pops and a frozen counter. With TOKEN_SCHED_PERF_EN, stall_cycles_o increments.
  - Release afull: pops resume with ipsum_pop = 0xFFFFFFFF.
- accumulate = 0 with all ipsum FIFOs empty: the tile completes; ipsum_pop stays 0 throughout.
- tile_len = 0, n = 0 (treated as 32): 32 preheat pops, DRAIN, done_o; no normal-loop pops and no pushes.
- Edge cases:
  - start_i while busy is ignored.
  - rst during DRAIN gives all outputs 0 the next cycle, with no push after reset.

Source files
------------

// File: rtl/token_engine_pkg.sv
// Shared types and defaults for the token-engine sequencing blocks.
// Holds the scheduler state enum, the layer type enum and array sizing defaults.
package token_engine_pkg;

    localparam int NUM_COL_DEF  = 32;
    localparam int PIPE_LAT_DEF = 4;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PREHEAT     = 3'd1,
        NORMAL_LOOP = 3'd2,
        DRAIN       = 3'd3,
        DONE        = 3'd4
    } tsched_state_e;

    typedef enum logic [1:0] {
        PW  = 2'd0,
        DW  = 2'd1,
        STD = 2'd2,
        LIN = 2'd3
    } layer_type_e;

endpackage

// File: rtl/token_push_delay.sv
// Fixed-depth delay line for normal-loop fire bits; the tail bit drives the opsum push
// and all_zero tells the scheduler that no push is still in flight.
module token_push_delay
    import token_engine_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT_DEF
) (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic dout,
    output logic all_zero
);

    logic [DEPTH-1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            stage_reg <= '0;
        end else begin
            stage_reg[0] <= din;
            for (int i = DEPTH - 1; i > 0; i--) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign dout     = stage_reg[DEPTH-1];
    assign all_zero = ~|stage_reg;

endmodule

// File: rtl/token_pop_scheduler.sv
// Tile sequencer (IDLE/PREHEAT/NORMAL_LOOP/DRAIN/DONE) issuing per-column FIFO pops and delayed pushes.
// Optional stall_cycles_o performance counter when TOKEN_SCHED_PERF_EN is defined.
module token_pop_scheduler
    import token_engine_pkg::*;
#(
    parameter int NUM_COL  = NUM_COL_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int LEN_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         layer_type_i,
    input  logic               accumulate_i,
    input  logic [5:0]         num_cols_i,
    input  logic [LEN_W-1:0]   tile_len_i,
    input  logic [NUM_COL-1:0] ifmap_fifo_empty_matrix_i,
    input  logic [NUM_COL-1:0] ipsum_fifo_empty_matrix_i,
    input  logic [NUM_COL-1:0] opsum_fifo_afull_matrix_i,
    output logic               preheat_state_o,
    output logic               normal_loop_state_o,
    output logic [NUM_COL-1:0] ifmap_fifo_pop_matrix_o,
    output logic [NUM_COL-1:0] ipsum_fifo_pop_matrix_o,
    output logic [NUM_COL-1:0] ipsum_fifo_push_matrix_o,
    output logic               busy_o,
    output logic               done_o
`ifdef TOKEN_SCHED_PERF_EN
    ,
    output logic [31:0]        stall_cycles_o
`endif
);

    localparam logic [5:0] NUM_COL_N = 6'(NUM_COL);

    tsched_state_e      state_reg, state_next;
    layer_type_e        layer_type_reg;
    logic               acc_reg;
    logic [NUM_COL-1:0] col_mask_reg, col_mask_start;
    logic [5:0]         n_eff, last_col_reg;
    logic [5:0]         k_reg, k_next;
    logic [LEN_W-1:0]   tile_len_reg, tok_reg, tok_next;
    logic               capture, fire, fire_ok;
    logic [NUM_COL-1:0] preheat_pop, ifmap_ok, ipsum_ok, opsum_ok;
    logic               push_tail, pipe_zero;
    logic               unused_cfg;

    // Column count of 0 or beyond the array width means the full array.
    assign n_eff = (num_cols_i == 6'd0 || num_cols_i > NUM_COL_N) ? NUM_COL_N : num_cols_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COL; gi++) begin : g_col
            assign col_mask_start[gi] = (6'(gi) < n_eff);
            assign preheat_pop[gi]    = (k_reg == 6'(gi)) && !ifmap_fifo_empty_matrix_i[gi];
            assign ifmap_ok[gi]       = !col_mask_reg[gi] || !ifmap_fifo_empty_matrix_i[gi];
            assign ipsum_ok[gi]       = !col_mask_reg[gi] || !ipsum_fifo_empty_matrix_i[gi];
            assign opsum_ok[gi]       = !col_mask_reg[gi] || !opsum_fifo_afull_matrix_i[gi];
        end
    endgenerate

    assign fire_ok = (&ifmap_ok) && (!acc_reg || (&ipsum_ok)) && (&opsum_ok);

    always_comb begin
        state_next              = state_reg;
        k_next                  = k_reg;
        tok_next                = tok_reg;
        capture                 = 1'b0;
        fire                    = 1'b0;
        ifmap_fifo_pop_matrix_o = '0;
        ipsum_fifo_pop_matrix_o = '0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    capture    = 1'b1;
                    state_next = PREHEAT;
                end
            end
            PREHEAT: begin
                // Skew fill: one column per pop, only when that column has data.
                ifmap_fifo_pop_matrix_o = preheat_pop;
                if (|preheat_pop) begin
                    if (k_reg == last_col_reg) begin
                        state_next = (tile_len_reg == '0) ? DRAIN : NORMAL_LOOP;
                    end else begin
                        k_next = k_reg + 6'd1;
                    end
                end
            end
            NORMAL_LOOP: begin
                if (fire_ok) begin
                    fire                    = 1'b1;
                    ifmap_fifo_pop_matrix_o = col_mask_reg;
                    ipsum_fifo_pop_matrix_o = acc_reg ? col_mask_reg : '0;
                    tok_next                = tok_reg + LEN_W'(1);
                    if (tok_next == tile_len_reg) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_zero) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            layer_type_reg <= PW;
            acc_reg        <= 1'b0;
            col_mask_reg   <= '0;
            last_col_reg   <= '0;
            tile_len_reg   <= '0;
            k_reg          <= '0;
            tok_reg        <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            tok_reg   <= tok_next;
            if (capture) begin
                layer_type_reg <= layer_type_e'(layer_type_i);
                acc_reg        <= accumulate_i;
                col_mask_reg   <= col_mask_start;
                last_col_reg   <= n_eff - 6'd1;
                tile_len_reg   <= tile_len_i;
                k_reg          <= '0;
                tok_reg        <= '0;
            end
        end
    end

    // Layer type is held only for the downstream controller; sequencing ignores it.
    assign unused_cfg = ^layer_type_reg;

    token_push_delay #(
        .DEPTH (PIPE_LAT)
    ) u_push_delay (
        .clk      (clk),
        .srst     (rst),
        .din      (fire),
        .dout     (push_tail),
        .all_zero (pipe_zero)
    );

    assign ipsum_fifo_push_matrix_o = push_tail ? col_mask_reg : '0;
    assign preheat_state_o          = (state_reg == PREHEAT);
    assign normal_loop_state_o      = (state_reg == NORMAL_LOOP);
    assign busy_o                   = (state_reg != IDLE);
    assign done_o                   = (state_reg == DONE);

`ifdef TOKEN_SCHED_PERF_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || capture) begin
            stall_cnt_reg <= '0;
        end else if (state_reg == NORMAL_LOOP && !fire && stall_cnt_reg != 32'hFFFF_FFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_token_pop_scheduler.sv
// Randomized self-checking bench for token_pop_scheduler against a cycle-level reference model
// built from tile rules (phase number, column index, token count, queue of push due-cycles).
module tb_token_pop_scheduler;

    localparam int NC = 32;
    localparam int PL = 4;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    layer_type_i = '0;
    logic          accumulate_i = 1'b0;
    logic [5:0]    num_cols_i = '0;
    logic [LW-1:0] tile_len_i = '0;
    logic [NC-1:0] ifmap_empty = '0, ipsum_empty = '0, opsum_afull = '0;
    logic          preheat_state_o, normal_loop_state_o, busy_o, done_o;
    logic [NC-1:0] ifmap_pop, ipsum_pop, opsum_push;
`ifdef TOKEN_SCHED_PERF_EN
    logic [31:0]   stall_cycles_o;
`endif

    always #5 clk = ~clk;

    token_pop_scheduler dut (
        .clk                       (clk),
        .rst                       (rst),
        .start_i                   (start_i),
        .layer_type_i              (layer_type_i),
        .accumulate_i              (accumulate_i),
        .num_cols_i                (num_cols_i),
        .tile_len_i                (tile_len_i),
        .ifmap_fifo_empty_matrix_i (ifmap_empty),
        .ipsum_fifo_empty_matrix_i (ipsum_empty),
        .opsum_fifo_afull_matrix_i (opsum_afull),
        .preheat_state_o           (preheat_state_o),
        .normal_loop_state_o       (normal_loop_state_o),
        .ifmap_fifo_pop_matrix_o   (ifmap_pop),
        .ipsum_fifo_pop_matrix_o   (ipsum_pop),
        .ipsum_fifo_push_matrix_o  (opsum_push),
        .busy_o                    (busy_o),
        .done_o                    (done_o)
`ifdef TOKEN_SCHED_PERF_EN
        ,
        .stall_cycles_o            (stall_cycles_o)
`endif
    );

    // Reference model: phase 0 idle, 1 preheat, 2 normal loop, 3 drain, 4 done.
    int          ph = 0;
    int          m_n = 0, m_k = 0, m_tok = 0, m_len = 0;
    bit          m_acc = 1'b0, m_fire = 1'b0;
    logic [NC-1:0] m_mask = '0;
    logic [31:0] m_stall = '0;
    int          cyc = 0;
    int          due_q[$];
    int          tiles_done = 0;
    int          checks = 0, errors = 0;

    logic [3*NC+3:0] exp_vec, obs_vec;
    logic [31:0]     exp_stall, obs_stall;
    logic            obs_done;
    logic [NC-1:0]   obs_ifpop;

    task automatic model_eval();
        logic [NC-1:0] e_if, e_ip, e_push;
        e_if = '0; e_ip = '0; m_fire = 1'b0;
        if (ph == 1 && !ifmap_empty[m_k]) e_if[m_k] = 1'b1;
        if (ph == 2) begin
            m_fire = 1'b1;
            for (int i = 0; i < m_n; i++)
                if (ifmap_empty[i] || (m_acc && ipsum_empty[i]) || opsum_afull[i]) m_fire = 1'b0;
            if (m_fire) begin
                e_if = m_mask;
                e_ip = m_acc ? m_mask : '0;
            end
        end
        e_push = (due_q.size() > 0 && due_q[0] == cyc) ? m_mask : '0;
        exp_vec = {ph != 0, ph == 4, ph == 1, ph == 2, e_if, e_ip, e_push};
        exp_stall = m_stall;
    endtask

    task automatic model_commit();
        bit pipe_empty;
        logic [63:0] tmp;
        pipe_empty = (due_q.size() == 0);
        if (rst) begin
            ph = 0;
            due_q.delete();
            m_stall = '0;
        end else begin
            if (due_q.size() > 0 && due_q[0] == cyc) void'(due_q.pop_front());
            if (m_fire) due_q.push_back(cyc + PL);
            case (ph)
                0: if (start_i) begin
                    m_n = (num_cols_i == 0 || num_cols_i > 6'd32) ? 32 : int'(num_cols_i);
                    tmp = (64'd1 << m_n) - 64'd1;
                    m_mask = tmp[NC-1:0];
                    m_len = int'(tile_len_i);
                    m_acc = accumulate_i;
                    m_k = 0; m_tok = 0; m_stall = '0;
                    ph = 1;
                end
                1: if (!ifmap_empty[m_k]) begin
                    if (m_k == m_n - 1) ph = (m_len == 0) ? 3 : 2;
                    else m_k++;
                end
                2: if (m_fire) begin
                    m_tok++;
                    if (m_tok == m_len) ph = 3;
                end else if (m_stall != 32'hFFFF_FFFF) begin
                    m_stall = m_stall + 32'd1;
                end
                3: if (pipe_empty) ph = 4;
                default: begin
                    ph = 0;
                    tiles_done++;
                    $display("tile %0d complete: n=%0d len=%0d acc=%0d at cycle %0d", tiles_done, m_n, m_len, m_acc, cyc);
                end
            endcase
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        obs_vec = {busy_o, done_o, preheat_state_o, normal_loop_state_o, ifmap_pop, ipsum_pop, opsum_push};
        obs_done = done_o;
        obs_ifpop = ifmap_pop;
`ifdef TOKEN_SCHED_PERF_EN
        obs_stall = stall_cycles_o;
`else
        obs_stall = exp_stall;
`endif
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic rand_inputs(int pe, int pi, int pa);
        for (int i = 0; i < NC; i++) begin
            ifmap_empty[i] = ($urandom_range(99) < pe);
            ipsum_empty[i] = ($urandom_range(99) < pi);
            opsum_afull[i] = ($urandom_range(99) < pa);
        end
    endtask

    task automatic launch(int n, int len, bit acc);
        num_cols_i = 6'(n); tile_len_i = LW'(len); accumulate_i = acc;
        layer_type_i = 2'($urandom_range(3)); start_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_inputs(50, 50, 50);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        rst = 1'b0; start_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
    endtask

    task automatic test_nominal();
        int t0, done_tick;
        t0 = tiles_done; done_tick = -1;
        ifmap_empty = '0; ipsum_empty = '0; opsum_afull = '0;
        launch(4, 3, 1'b1);
        for (int c = 0; c < 100 && tiles_done == t0; c++) begin
            tick();
            start_i = 1'b0;
            if (obs_done && done_tick < 0) done_tick = c;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL nominal cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        checks++;
        if (done_tick !== 1 + 4 + 3 + PL + 1) begin errors++; $display("FAIL nominal_done_cycle got=%0d want=%0d", done_tick, 1 + 4 + 3 + PL + 1); end
    endtask

    task automatic test_preheat_stall();
        int t0, col2_pops, bad_pops;
        t0 = tiles_done; col2_pops = 0; bad_pops = 0;
        ipsum_empty = '0; opsum_afull = '0;
        launch(4, 2, 1'b1);
        for (int c = 0; c < 100 && tiles_done == t0; c++) begin
            ifmap_empty = (c >= 2 && c <= 6) ? 32'h4 : 32'h0;
            tick();
            start_i = 1'b0;
            if (ph == 1 || (ph == 2 && m_tok == 0 && !m_fire)) ; // no-op keeps phases readable
            if (obs_ifpop == 32'h4) col2_pops++;
            if (obs_ifpop[2] && ifmap_empty[2]) bad_pops++;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL preheat_stall cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        checks++;
        if (col2_pops !== 1 || bad_pops !== 0) begin errors++; $display("FAIL preheat_col2 got pops=%0d bad=%0d want pops=1 bad=0", col2_pops, bad_pops); end
    endtask

    task automatic test_backpressure();
        int t0;
        t0 = tiles_done;
        ifmap_empty = '0; ipsum_empty = '0; opsum_afull = '0;
        launch(32, 4, 1'b1);
        for (int c = 0; c < 200 && tiles_done == t0; c++) begin
            opsum_afull = (c >= 34 && c <= 39) ? 32'h8000_0000 : 32'h0;
            tick();
            start_i = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL backpressure cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
`ifdef TOKEN_SCHED_PERF_EN
            checks++;
            if (obs_stall !== exp_stall) begin errors++; $display("FAIL stall_count cyc=%0d got=%0d want=%0d", cyc, obs_stall, exp_stall); end
`endif
        end
        checks++;
        if (tiles_done == t0) begin errors++; $display("FAIL backpressure_timeout got=busy want=done"); end
    endtask

    task automatic test_no_accumulate();
        int t0;
        t0 = tiles_done;
        launch($urandom_range(8, 1), 5, 1'b0);
        for (int c = 0; c < 500 && tiles_done == t0; c++) begin
            rand_inputs(5, 0, 3);
            ipsum_empty = '1;
            tick();
            start_i = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL no_accumulate cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        checks++;
        if (tiles_done == t0) begin errors++; $display("FAIL no_accumulate_timeout got=busy want=done"); end
    endtask

    task automatic test_len_zero();
        int t0;
        t0 = tiles_done;
        ifmap_empty = '0; ipsum_empty = '0; opsum_afull = '0;
        launch(0, 0, 1'b1);
        for (int c = 0; c < 100 && tiles_done == t0; c++) begin
            tick();
            start_i = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL len_zero cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        checks++;
        if (tiles_done == t0) begin errors++; $display("FAIL len_zero_timeout got=busy want=done"); end
    endtask

    task automatic test_random_tiles();
        for (int t = 0; t < 8; t++) begin
            int t0;
            t0 = tiles_done;
            launch($urandom_range(40), $urandom_range(6), 1'($urandom_range(1)));
            for (int c = 0; c < 3000 && tiles_done == t0; c++) begin
                rand_inputs(3, 3, 2);
                tick();
                // Start pulses and config changes while busy must be ignored.
                start_i = (ph != 0) && ($urandom_range(3) == 0);
                num_cols_i = 6'($urandom_range(63));
                tile_len_i = LW'($urandom_range(9));
                accumulate_i = 1'($urandom_range(1));
                checks++;
                if (obs_vec !== exp_vec) begin errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
`ifdef TOKEN_SCHED_PERF_EN
                checks++;
                if (obs_stall !== exp_stall) begin errors++; $display("FAIL random_stall cyc=%0d got=%0d want=%0d", cyc, obs_stall, exp_stall); end
`endif
            end
            start_i = 1'b0;
            checks++;
            if (tiles_done == t0) begin errors++; $display("FAIL random_timeout tile=%0d got=busy want=done", t); end
        end
    endtask

    task automatic test_reset_drain();
        int c;
        ifmap_empty = '0; ipsum_empty = '0; opsum_afull = '0;
        launch(3, 4, 1'b1);
        c = 0;
        while (c < 100 && !(ph == 3 && due_q.size() > 1)) begin
            tick();
            start_i = 1'b0;
            c++;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL drain_run cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        checks++;
        if (ph != 3) begin errors++; $display("FAIL drain_reach got=phase%0d want=phase3", ph); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec || (k == 0 && obs_vec !== '0)) begin
                errors++; $display("FAIL reset_drain cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_preheat_stall();
        test_backpressure();
        test_no_accumulate();
        test_len_zero();
        test_random_tiles();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
